cnn_frame_streamer: RTL

//  Source end of the CNN pixel interface: buffers one IMG_W x IMG_H frame written by the host,

---
 rtl/cnn_frame_streamer_pkg.sv | 24 ++
 rtl/cnn_frame_streamer_ram.sv | 29 ++
 rtl/cnn_frame_streamer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cnn_frame_streamer_pkg.sv
// Shared constants, FSM state type and counter-width helper
// for the CNN frame streamer.
package cnn_frame_streamer_pkg;

    localparam int ISP_BW        = 32;
    localparam int CNN_IMG_W     = 28;
    localparam int CNN_IMG_H     = 28;
    localparam int CNN_FRAME_PIX = CNN_IMG_W * CNN_IMG_H;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_WAIT,
        S_DONE,
        S_TIMEOUT
    } state_t;

    // Width of a counter that must hold 0..n; never narrower than 1 bit
    function automatic int cnt_bw(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cnn_frame_streamer_ram.sv
// Frame buffer: simple dual-port RAM, host write port plus one
// registered read port. Ports: clk, we/waddr/wdata, re/raddr, rdata.
module cnn_frame_streamer_ram #(
    parameter int DEPTH   = 784,
    parameter int PX_BW   = 32,
    parameter int ADDR_BW = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_BW-1:0] waddr,
    input  logic [PX_BW-1:0]   wdata,
    input  logic               re,
    input  logic [ADDR_BW-1:0] raddr,
    output logic [PX_BW-1:0]   rdata
);

    logic [PX_BW-1:0] mem [DEPTH];

    // No reset on storage or read register so this maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cnn_frame_streamer.sv
// Buffers one frame from the host, streams it in raster order to the
// CNN input, then waits for the classifier result or times out.
// Ports: clk/reset; host write i_wr_*; i_start; pixel out o_pixel*;
// result in i_result_valid/i_alpha; status o_busy/o_done/o_timeout/
// o_alpha/o_wr_err.
module cnn_frame_streamer
    import cnn_frame_streamer_pkg::*;
#(
    parameter int IMG_W   = CNN_IMG_W,
    parameter int IMG_H   = CNN_IMG_H,
    parameter int PX_BW   = ISP_BW,
    parameter int ADDR_BW = 10,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_en,
    input  logic [ADDR_BW-1:0] i_wr_addr,
    input  logic [PX_BW-1:0]   i_wr_data,
    input  logic               i_start,
    output logic               o_pixel_valid,
    output logic [PX_BW-1:0]   o_pixel,
    input  logic               i_result_valid,
    input  logic [7:0]         i_alpha,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [7:0]         o_alpha,
    output logic               o_wr_err
);

    localparam int FRAME = IMG_W * IMG_H;
    localparam int GW    = cnt_bw(GAP);
    localparam int TW    = cnt_bw(TIMEOUT);

    localparam logic [ADDR_BW-1:0] LAST_PIX = ADDR_BW'(FRAME - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_BW-1:0] pix_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [TW-1:0]      to_cnt;
    logic               res_seen;
    logic [7:0]         alpha_q;
    logic               wr_err_q;
    logic               pix_valid_q;
    logic [PX_BW-1:0]   rd_data;

    logic busy;
    logic issue;
    logic last_pix;
    logic start_ok;
    logic res_take;
    logic wr_ok;

    assign busy     = state inside {S_STREAM, S_GAP, S_WAIT};
    assign issue    = (state == S_STREAM);
    assign last_pix = (pix_cnt == LAST_PIX);
    assign start_ok = (state == S_IDLE) && i_start;
    // Only the first result of a frame is kept
    assign res_take = i_result_valid && busy && !res_seen;
    assign wr_ok    = i_wr_en && (state == S_IDLE)
                    && (int'(i_wr_addr) < FRAME);

    cnn_frame_streamer_ram #(
        .DEPTH   (FRAME),
        .PX_BW   (PX_BW),
        .ADDR_BW (ADDR_BW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (i_wr_addr),
        .wdata (i_wr_data),
        .re    (issue),
        .raddr (pix_cnt),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // A result seen earlier (or right now) skips the wait
                if (last_pix) begin
                    state_nxt = (res_seen || i_result_valid)
                              ? S_DONE : S_WAIT;
                end else if (GAP > 0) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_STREAM;
                end
            end
            S_WAIT: begin
                if (i_result_valid) begin
                    state_nxt = S_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            S_TIMEOUT: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt     <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            res_seen    <= 1'b0;
            alpha_q     <= '0;
            wr_err_q    <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            // Read data lands one cycle after the address is issued
            pix_valid_q <= issue;
            wr_err_q    <= i_wr_en && (state != S_IDLE);

            if (start_ok) begin
                pix_cnt  <= '0;
                gap_cnt  <= '0;
                res_seen <= 1'b0;
            end else if (issue && !last_pix) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (state == S_GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            end

            if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (res_take) begin
                alpha_q  <= i_alpha;
                res_seen <= 1'b1;
            end
        end
    end

    assign o_pixel_valid = pix_valid_q;
    assign o_pixel       = pix_valid_q ? rd_data : '0;
    assign o_busy        = busy;
    assign o_done        = (state == S_DONE);
    assign o_timeout     = (state == S_TIMEOUT);
    assign o_alpha       = alpha_q;
    assign o_wr_err      = wr_err_q;

endmodule
